load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core's execute/memory stage and the memory interface block that decodes addresses into the code and data RAMs. Accepts one load or store request at a time via a ready/valid handshake. Converts RV32I funct3 width and signedness into byte lanes, replicated write data and sign- or zero-extended read data. Sequences the synchronous RAM access over a parameterised read latency and flags misaligned or illegal accesses without touching memory.

## Interface
- MEM_LATENCY, 1: iCLK cycles from read-enable assertion until iReadData is valid; legal range 1..7.
- iCLK  in  1  core clock; all state changes on rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iReq  in  1  request strobe; sampled only while oReady=1.
- iWe  in  1  1 = store, 0 = load.
- iFunct3  in  3  RV32I width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- iAddr  in  32  byte address.
- iWData  in  32  store data, right-aligned.
- oReady  out  1  high only in IDLE.
- oValid  out  1  one-cycle completion pulse for loads, stores and faults.
- oRData  out  32  extended load result; held until the next oValid.
- oFault  out  1  qualified by oValid: access was misaligned or illegal.
- oReadEnable  out  1  to memory interface.
- oWriteEnable  out  1  to memory interface.
- oByteEnable  out  4  lane mask; bit i selects byte [8i+7:8i].
- oAddress  out  32  registered copy of iAddr, low bits unmodified.
- oWriteData  out  32  lane-replicated store data.
- iReadData  in  32  word returned by the memory interface.

## Operation
- States: IDLE, READ, WRITE, DONE. Reset: IDLE; oReady=1; every other output 0.
- IDLE & iReq: register iAddr, iWe, iFunct3 and iWData; classify the request.
  - Fault: h/hu/sh with addr[0]=1; w/sw with addr[1:0]≠0; load funct3 in {011,110,111}; store funct3 ≥ 011. Goes to DONE with oFault=1 and oRData=0. No enable is raised.
  - Load: goes to READ. Store: goes to WRITE.
- Lanes:
  - byte: 0001<<addr[1:0], data {4{d[7:0]}}.
  - half: addr[1]=0 → 0011, addr[1]=1 → 1100; data {2{d[15:0]}}.
  - word: 1111, data d.
  - Loads drive the same lane mask.
- READ: oReadEnable=1 with address and lanes stable, using a 3-bit counter. After exactly MEM_LATENCY cycles, capture iReadData on the last READ edge. Extract the byte at offset addr[1:0], or the half at addr[1]. Sign-extend for b/h, zero-extend for bu/hu. Write the result to oRData and go to DONE.
- WRITE: exactly one cycle with oWriteEnable=1, then DONE. A store never updates oRData.
- DONE: oValid=1 for one cycle, then IDLE.
- iReq outside IDLE is ignored; the upstream stage must hold its request until it sees oReady.
- An asynchronous reset mid-access drops both enables immediately, aborts the access and loses it.

## Timing
- Accept edge = cycle N.
- Load: oReadEnable high for cycles N+1 .. N+MEM_LATENCY; oValid at N+MEM_LATENCY+1. Default: 3-cycle occupancy, next accept at N+MEM_LATENCY+2.
- Store: oWriteEnable at N+1, oValid at N+2.
- Fault: oValid at N+1.
- oReadEnable and oWriteEnable are never high together. Memory-side outputs are registered, with no combinational path from the core inputs.

## Structure
- Shared package (lsu_pkg):
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding.
  - Helper functions is_misaligned and lane_mask.
  - Add alongside the existing address-map parameters.
- One combinational sub-module lsu_align:
  - Inputs: funct3 and addr[1:0].
  - Outputs: byte enables, replicated write data, and the extended result from a raw word.
- FSM, counter and registers live in load_store_unit.

## Test plan
- Reset mid-READ (MEM_LATENCY=2, lw 0x10010000): enables drop immediately; after release oReady=1, no oValid.
- sb 0xA5 to 0x10010003: oByteEnable=1000, oWriteData=A5A5A5A5, oWriteEnable one cycle at N+1, oValid at N+2, oFault=0.
- Word 0x8000FF7F at 0x10010000. lb addr+0 → 0000007F. lb addr+1 → FFFFFFFF. lbu addr+1 → 000000FF. lh addr+2 → FFFF8000. lhu addr+2 → 00008000.
- lw 0x10010002 and sh 0x10010001: oValid at N+1, oFault=1, oRData=0, no enable asserted. Same for iFunct3=011 load.
- MEM_LATENCY=3, lw: oReadEnable for 3 cycles, oValid at N+4. iReq held high throughout is accepted only once per IDLE.
- Back-to-back sw then lw to the same address: load returns the stored word, oReady gaps exactly as in Timing.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - Address map of the code and data RAMs behind the memory interface.
//   - RV32I funct3 width/sign codes used by loads and stores.
//   - LSU state encoding.
//   - Helpers: is_misaligned, is_illegal, lane_mask.
package lsu_pkg;

    // Address map decoded by the memory interface block.
    localparam logic [31:0] CODE_BASE = 32'h0000_0000;
    localparam logic [31:0] CODE_SIZE = 32'h0001_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;
    localparam logic [31:0] DATA_SIZE = 32'h0001_0000;

    // RV32I load/store width and signedness codes.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } lsuState_e;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addrLow);
        logic result;
        case (funct3)
            F3_H, F3_HU: result = addrLow[0];
            F3_W:        result = (addrLow != 2'b00);
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

    // Loads accept b/h/w/bu/hu; stores only b/h/w.
    function automatic logic is_illegal(input logic isStore, input logic [2:0] funct3);
        logic result;
        if (isStore) begin
            result = (funct3 >= 3'b011);
        end else begin
            result = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        return result;
    endfunction

    // Lane mask depends only on the size bits, so bu/hu share b/h masks.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addrLow);
        logic [3:0] mask;
        case (funct3[1:0])
            2'b00:   mask = 4'b0001 << addrLow;
            2'b01:   mask = addrLow[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
//   funct3      : RV32I width/sign code
//   addrLow     : byte offset within the word
//   wData       : right-aligned store data
//   rawWord     : word returned by memory
//   byteEnable  : lane mask for the access
//   writeData   : store data replicated across all lanes
//   loadResult  : selected byte/half/word, sign- or zero-extended
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLow,
    input  logic [31:0] wData,
    input  logic [31:0] rawWord,
    output logic [3:0]  byteEnable,
    output logic [31:0] writeData,
    output logic [31:0] loadResult
);

    logic [7:0]  byteLane [4];
    logic [7:0]  selByte;
    logic [15:0] selHalf;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byteLane[gi] = rawWord[8*gi +: 8];
        end
    endgenerate

    assign byteEnable = lane_mask(funct3, addrLow);

    always_comb begin
        selByte    = byteLane[addrLow];
        selHalf    = addrLow[1] ? rawWord[31:16] : rawWord[15:0];
        writeData  = wData;
        loadResult = rawWord;
        case (funct3[1:0])
            2'b00: begin
                writeData  = {4{wData[7:0]}};
                // funct3[2] distinguishes the unsigned variants.
                loadResult = funct3[2] ? {24'b0, selByte} : {{24{selByte[7]}}, selByte};
            end
            2'b01: begin
                writeData  = {2{wData[15:0]}};
                loadResult = funct3[2] ? {16'b0, selHalf} : {{16{selHalf[15]}}, selHalf};
            end
            default: begin
                writeData  = wData;
                loadResult = rawWord;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute/memory stage and the memory interface.
// Accepts one request at a time (iReq sampled while oReady), classifies it,
// then runs a READ phase of MEM_LATENCY cycles, a single WRITE cycle, or goes
// straight to DONE on a fault. oValid pulses for one cycle in DONE.
//   Core side  : iReq, iWe, iFunct3, iAddr, iWData -> oReady, oValid, oRData, oFault
//   Memory side: oReadEnable, oWriteEnable, oByteEnable, oAddress, oWriteData <- iReadData
// All memory-side outputs come straight from registers.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    output logic        oReady,
    output logic        oValid,
    output logic [31:0] oRData,
    output logic        oFault,
    output logic        oReadEnable,
    output logic        oWriteEnable,
    output logic [3:0]  oByteEnable,
    output logic [31:0] oAddress,
    output logic [31:0] oWriteData,
    input  logic [31:0] iReadData
);

    localparam logic [2:0] LAST_COUNT = 3'(MEM_LATENCY - 1);

    lsuState_e   stateReg, stateNext;
    logic [2:0]  latCountReg;
    logic [2:0]  funct3Reg;
    logic [31:0] addrReg;
    logic [31:0] rDataReg;
    logic [31:0] writeDataReg;
    logic [3:0]  byteEnableReg;
    logic        readEnableReg, writeEnableReg, validReg, faultReg;
    logic        readEnableNext, writeEnableNext, validNext;

    logic        accept;
    logic        reqFault;
    logic        readDone;
    logic [2:0]  alignFunct3;
    logic [1:0]  alignAddrLow;
    logic [3:0]  alignByteEnable;
    logic [31:0] alignWriteData;
    logic [31:0] alignLoadResult;

    assign accept   = (stateReg == IDLE) && iReq;
    assign reqFault = is_misaligned(iFunct3, iAddr[1:0]) || is_illegal(iWe, iFunct3);
    assign readDone = (stateReg == READ) && (latCountReg == LAST_COUNT);

    // One aligner serves both ends: request-side lanes while IDLE, and
    // extraction of the returned word from the registered request otherwise.
    assign alignFunct3  = (stateReg == IDLE) ? iFunct3    : funct3Reg;
    assign alignAddrLow = (stateReg == IDLE) ? iAddr[1:0] : addrReg[1:0];

    lsu_align u_align (
        .funct3     (alignFunct3),
        .addrLow    (alignAddrLow),
        .wData      (iWData),
        .rawWord    (iReadData),
        .byteEnable (alignByteEnable),
        .writeData  (alignWriteData),
        .loadResult (alignLoadResult)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Enables and oValid are registered from the next state so they line up
    // exactly with the state they belong to.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (iReq) begin
                    if (reqFault) begin
                        stateNext = DONE;
                    end else if (iWe) begin
                        stateNext = WRITE;
                    end else begin
                        stateNext = READ;
                    end
                end
            end
            READ:    if (latCountReg == LAST_COUNT) stateNext = DONE;
            WRITE:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        readEnableNext  = (stateNext == READ);
        writeEnableNext = (stateNext == WRITE);
        validNext       = (stateNext == DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            latCountReg    <= 3'd0;
            funct3Reg      <= 3'd0;
            addrReg        <= 32'd0;
            rDataReg       <= 32'd0;
            writeDataReg   <= 32'd0;
            byteEnableReg  <= 4'd0;
            readEnableReg  <= 1'b0;
            writeEnableReg <= 1'b0;
            validReg       <= 1'b0;
            faultReg       <= 1'b0;
        end else begin
            readEnableReg  <= readEnableNext;
            writeEnableReg <= writeEnableNext;
            validReg       <= validNext;

            // Counts READ cycles; restarts from zero for every access.
            if (stateReg == READ) begin
                latCountReg <= latCountReg + 3'd1;
            end else begin
                latCountReg <= 3'd0;
            end

            if (accept) begin
                addrReg       <= iAddr;
                funct3Reg     <= iFunct3;
                faultReg      <= reqFault;
                byteEnableReg <= reqFault ? 4'd0 : alignByteEnable;
                writeDataReg  <= (iWe && !reqFault) ? alignWriteData : 32'd0;
                if (reqFault) begin
                    rDataReg <= 32'd0;
                end
            end

            if (readDone) begin
                rDataReg <= alignLoadResult;
            end
        end
    end

    assign oReady       = (stateReg == IDLE);
    assign oValid       = validReg;
    assign oRData       = rDataReg;
    assign oFault       = faultReg;
    assign oReadEnable  = readEnableReg;
    assign oWriteEnable = writeEnableReg;
    assign oByteEnable  = byteEnableReg;
    assign oAddress     = addrReg;
    assign oWriteData   = writeDataReg;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios followed by random
// loads/stores, checked against a byte-addressed reference memory.
module tb_load_store_unit;

    localparam int LAT = 3;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iReq = 1'b0;
    logic        iWe = 1'b0;
    logic [2:0]  iFunct3 = 3'd0;
    logic [31:0] iAddr = 32'd0;
    logic [31:0] iWData = 32'd0;
    logic        oReady, oValid, oFault, oReadEnable, oWriteEnable;
    logic [31:0] oRData, oAddress, oWriteData;
    logic [3:0]  oByteEnable;
    logic [31:0] iReadData = 32'd0;

    int checks = 0;
    int errors = 0;

    // Memory seen through the DUT's memory-side port.
    logic [7:0]  envMem [0:1023] = '{default: 8'h00};
    int          rdCnt = 0;
    // Reference memory updated from the request alone.
    logic [7:0]  refMem [0:1023];
    logic [31:0] lastRData = 32'd0;

    always #5 iCLK = ~iCLK;

    load_store_unit #(.MEM_LATENCY(LAT)) dut (
        .iCLK         (iCLK),
        .iRST_N       (iRST_N),
        .iReq         (iReq),
        .iWe          (iWe),
        .iFunct3      (iFunct3),
        .iAddr        (iAddr),
        .iWData       (iWData),
        .oReady       (oReady),
        .oValid       (oValid),
        .oRData       (oRData),
        .oFault       (oFault),
        .oReadEnable  (oReadEnable),
        .oWriteEnable (oWriteEnable),
        .oByteEnable  (oByteEnable),
        .oAddress     (oAddress),
        .oWriteData   (oWriteData),
        .iReadData    (iReadData)
    );

    // Memory responder: the word is only valid in the LAT-th read-enable
    // cycle; any other cycle returns noise.
    always @(negedge iCLK) begin
        if (oReadEnable) begin
            rdCnt <= rdCnt + 1;
            if (rdCnt + 1 == LAT) begin
                iReadData <= {envMem[{oAddress[9:2], 2'd3}], envMem[{oAddress[9:2], 2'd2}],
                              envMem[{oAddress[9:2], 2'd1}], envMem[{oAddress[9:2], 2'd0}]};
            end else begin
                iReadData <= $urandom;
            end
        end else begin
            rdCnt <= 0;
            iReadData <= $urandom;
        end
    end

    always @(posedge iCLK) begin
        if (oWriteEnable) begin
            for (int k = 0; k < 4; k++) begin
                if (oByteEnable[k]) envMem[{oAddress[9:2], 2'(k)}] <= oWriteData[8*k +: 8];
            end
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int sizeOf(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit refFault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 1'b1;
        return (int'(addr[1:0]) % sizeOf(f3)) != 0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        int size;
        v = 32'd0;
        size = sizeOf(f3);
        for (int i = 0; i < size; i++) v[8*i +: 8] = refMem[int'(addr[9:0]) + i];
        if (!f3[2] && size < 4 && v[8*size-1]) begin
            for (int i = 8 * size; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic doTxn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold);
        int waitCnt, validK, reFirst, reCount, weFirst, weCount, bothCount, size;
        bit fault;
        logic [31:0] expRData, expWData, seenAddr, seenWData, gotRData;
        logic [3:0]  expMask, seenMask;
        logic        gotFault;

        waitCnt = 0;
        while (!oReady && waitCnt < 50) begin
            @(negedge iCLK);
            waitCnt++;
        end
        checkValue("readyWait", 32'(oReady), 32'd1);

        fault = refFault(we, f3, addr);
        size  = sizeOf(f3);
        expMask = 4'd0;
        for (int i = 0; i < size; i++) expMask[int'(addr[1:0]) + i] = 1'b1;
        for (int k = 0; k < 4; k++) expWData[8*k +: 8] = wdata[8*(k % size) +: 8];
        expRData = fault ? 32'd0 : (we ? lastRData : refLoad(f3, addr));

        iReq = 1'b1; iWe = we; iFunct3 = f3; iAddr = addr; iWData = wdata;
        @(posedge iCLK);

        validK = 0; reFirst = 0; reCount = 0; weFirst = 0; weCount = 0; bothCount = 0;
        seenAddr = 32'd0; seenWData = 32'd0; seenMask = 4'd0; gotRData = 32'd0; gotFault = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge iCLK);
            if (k == 1) begin
                checkValue("busyNotReady", 32'(oReady), 32'd0);
                if (!hold) begin
                    iReq = 1'b0; iWe = 1'($urandom); iFunct3 = 3'($urandom);
                    iAddr = $urandom; iWData = $urandom;
                end
            end
            if (oReadEnable) begin
                reCount++;
                if (reFirst == 0) reFirst = k;
                seenMask = oByteEnable; seenAddr = oAddress;
            end
            if (oWriteEnable) begin
                weCount++;
                if (weFirst == 0) weFirst = k;
                seenMask = oByteEnable; seenAddr = oAddress; seenWData = oWriteData;
            end
            if (oReadEnable && oWriteEnable) bothCount++;
            if (oValid) begin
                validK = k; gotRData = oRData; gotFault = oFault;
                break;
            end
        end

        checkValue("validSeen", 32'(validK != 0), 32'd1);
        checkValue("bothEnables", 32'(bothCount), 32'd0);
        checkValue("fault", 32'(gotFault), 32'(fault));
        checkValue("rdata", gotRData, expRData);
        if (fault) begin
            checkValue("faultValidCycle", 32'(validK), 32'd1);
            checkValue("faultEnables", 32'(reCount + weCount), 32'd0);
        end else if (we) begin
            checkValue("storeValidCycle", 32'(validK), 32'd2);
            checkValue("storeWeFirst", 32'(weFirst), 32'd1);
            checkValue("storeWeCount", 32'(weCount), 32'd1);
            checkValue("storeReCount", 32'(reCount), 32'd0);
            checkValue("storeMask", 32'(seenMask), 32'(expMask));
            checkValue("storeWData", seenWData, expWData);
            checkValue("storeAddr", seenAddr, addr);
        end else begin
            checkValue("loadValidCycle", 32'(validK), 32'(LAT + 1));
            checkValue("loadReFirst", 32'(reFirst), 32'd1);
            checkValue("loadReCount", 32'(reCount), 32'(LAT));
            checkValue("loadWeCount", 32'(weCount), 32'd0);
            checkValue("loadMask", 32'(seenMask), 32'(expMask));
            checkValue("loadAddr", seenAddr, addr);
        end

        @(negedge iCLK);
        checkValue("readyAfterDone", 32'(oReady), 32'd1);
        checkValue("validOnePulse", 32'(oValid), 32'd0);

        if (!fault && we) begin
            for (int i = 0; i < size; i++) refMem[int'(addr[9:0]) + i] = wdata[8*i +: 8];
        end
        if (fault || !we) lastRData = expRData;

        $display("txn we=%0d f3=%0d addr=%08h wdata=%08h rdata=%08h fault=%0d validAt=%0d",
                 we, f3, addr, wdata, gotRData, gotFault, validK);
    endtask

    logic [31:0] rAddr;
    logic [2:0]  rF3;
    logic        rWe;
    bit          sawValid;

    initial begin
        for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;

        // Reset state.
        repeat (3) @(negedge iCLK);
        checkValue("rstReady", 32'(oReady), 32'd1);
        checkValue("rstValid", 32'(oValid), 32'd0);
        checkValue("rstReadEn", 32'(oReadEnable), 32'd0);
        checkValue("rstWriteEn", 32'(oWriteEnable), 32'd0);
        checkValue("rstRData", oRData, 32'd0);
        checkValue("rstFault", 32'(oFault), 32'd0);
        checkValue("rstByteEn", 32'(oByteEnable), 32'd0);
        checkValue("rstAddress", oAddress, 32'd0);
        checkValue("rstWriteData", oWriteData, 32'd0);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Asynchronous reset in the middle of a read.
        iReq = 1'b1; iWe = 1'b0; iFunct3 = 3'd2; iAddr = 32'h1001_0000;
        @(posedge iCLK);
        @(negedge iCLK);
        iReq = 1'b0;
        checkValue("midReadEn", 32'(oReadEnable), 32'd1);
        #2 iRST_N = 1'b0;
        #1;
        checkValue("abortReadEn", 32'(oReadEnable), 32'd0);
        checkValue("abortWriteEn", 32'(oWriteEnable), 32'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        sawValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge iCLK);
            if (oValid) sawValid = 1'b1;
        end
        checkValue("abortNoValid", 32'(sawValid), 32'd0);
        checkValue("abortReady", 32'(oReady), 32'd1);

        // Pre-fill a 64-byte window so random loads see real data.
        for (int i = 0; i < 16; i++) doTxn(1'b1, 3'd2, 32'h1001_0000 + 32'(4 * i), $urandom, 1'b0);

        // Byte store to the top lane.
        doTxn(1'b1, 3'd0, 32'h1001_0003, 32'h0000_00A5, 1'b0);

        // Sign/zero extension from a known word.
        doTxn(1'b1, 3'd2, 32'h1001_0000, 32'h8000_FF7F, 1'b0);
        doTxn(1'b0, 3'd0, 32'h1001_0000, 32'd0, 1'b0);
        doTxn(1'b0, 3'd0, 32'h1001_0001, 32'd0, 1'b0);
        doTxn(1'b0, 3'd4, 32'h1001_0001, 32'd0, 1'b0);
        doTxn(1'b0, 3'd1, 32'h1001_0002, 32'd0, 1'b0);
        doTxn(1'b0, 3'd5, 32'h1001_0002, 32'd0, 1'b0);

        // Faults: misaligned word/half and an illegal load code.
        doTxn(1'b0, 3'd2, 32'h1001_0002, 32'd0, 1'b0);
        doTxn(1'b1, 3'd1, 32'h1001_0001, 32'h1234_5678, 1'b0);
        doTxn(1'b0, 3'd3, 32'h1001_0000, 32'd0, 1'b0);

        // Request held high: one acceptance per IDLE.
        doTxn(1'b0, 3'd2, 32'h1001_0004, 32'd0, 1'b1);
        doTxn(1'b0, 3'd2, 32'h1001_0008, 32'd0, 1'b1);

        // Back-to-back store then load of the same word.
        doTxn(1'b1, 3'd2, 32'h1001_000C, 32'hDEAD_BEEF, 1'b0);
        doTxn(1'b0, 3'd2, 32'h1001_000C, 32'd0, 1'b0);

        // Random traffic inside the pre-filled window.
        for (int n = 0; n < 200; n++) begin
            rWe   = 1'($urandom_range(0, 1));
            rF3   = 3'($urandom_range(0, 7));
            rAddr = 32'h1001_0000 | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                rAddr = rAddr & ~32'(sizeOf(rF3) - 1);
            end
            doTxn(rWe, rF3, rAddr, $urandom, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL globalTimeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
